rf_wr_arbiter: RTL and testbench

Shares the single register-file write port among NREQ writeback requesters (default: IXU writeback and memory-unit load return). Each requester has its own DEPTH-entry FIFO. The arbiter grants the oldest buffered write each cycle and drives the port from a registered output. It raises a registered global pipeline stall before any FIFO can overflow. It sits between the writeback stages and the register file, replacing direct rd/data/wr_en connections.

---
 rtl/rf_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_rf_wr_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: per-requester FIFOs, oldest-first grant,
// registered write port and a registered stall raised before any FIFO can overflow.
module rf_wr_arbiter #(
    parameter int NREQ  = 2,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*5-1:0]   req_rd,
    input  logic [NREQ*32-1:0]  req_data,
    output logic                stall,
    output logic                wr_en,
    output logic [4:0]          wr_rd,
    output logic [31:0]         wr_data,
    output logic                overflow_err
);
    localparam int SW = $clog2(NREQ*DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

    logic [4:0]    rd_mem    [NREQ][DEPTH];
    logic [31:0]   data_mem  [NREQ][DEPTH];
    logic [SW-1:0] stamp_mem [NREQ][DEPTH];

    logic [PW-1:0] wptr      [NREQ];
    logic [PW-1:0] rptr      [NREQ];
    logic [CW-1:0] count     [NREQ];
    logic [CW-1:0] count_nxt [NREQ];

    logic [SW-1:0]   cnt;
    logic [NREQ-1:0] push_try;
    logic [NREQ-1:0] push_ok;
    logic [NREQ-1:0] pop;
    logic            grant_valid;
    logic [GW-1:0]   grant_idx;
    logic [SW-1:0]   best_age;
    logic [SW-1:0]   age;
    logic            stall_nxt;
    logic            stall_q;
    logic            overflow_q;

    // Full check uses the current count, so a full FIFO rejects a push even if it pops this cycle.
    always_comb begin
        push_try = '0;
        push_ok  = '0;
        for (int i = 0; i < NREQ; i++) begin
            push_try[i] = req_valid[i] && !stall_q && (req_rd[5*i +: 5] != 5'd0);
            push_ok[i]  = push_try[i] && (count[i] != FULL_CNT);
        end
    end

    // Oldest head wins; strict '>' keeps the lowest index on equal age.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        best_age    = '0;
        age         = '0;
        for (int i = 0; i < NREQ; i++) begin
            age = cnt - stamp_mem[i][rptr[i]];
            if ((count[i] != '0) && (!grant_valid || (age > best_age))) begin
                grant_valid = 1'b1;
                grant_idx   = GW'(i);
                best_age    = age;
            end
        end
        pop = '0;
        if (grant_valid) pop[grant_idx] = 1'b1;
    end

    always_comb begin
        stall_nxt = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            count_nxt[i] = count[i] + CW'(push_ok[i]) - CW'(pop[i]);
            if (count_nxt[i] >= STALL_CNT) stall_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push_ok[i]) begin
                rd_mem[i][wptr[i]]    <= req_rd[5*i +: 5];
                data_mem[i][wptr[i]]  <= req_data[32*i +: 32];
                stamp_mem[i][wptr[i]] <= cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            wr_en      <= 1'b0;
            wr_rd      <= '0;
            wr_data    <= '0;
            for (int i = 0; i < NREQ; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            cnt     <= cnt + SW'(1);
            stall_q <= stall_nxt;
            if (|(push_try & ~push_ok)) overflow_q <= 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                count[i] <= count_nxt[i];
                if (push_ok[i]) wptr[i] <= wptr[i] + PW'(1);
                if (pop[i])     rptr[i] <= rptr[i] + PW'(1);
            end
            wr_en <= grant_valid;
            if (grant_valid) begin
                wr_rd   <= rd_mem[grant_idx][rptr[grant_idx]];
                wr_data <= data_mem[grant_idx][rptr[grant_idx]];
            end
        end
    end

    assign stall        = stall_q;
    assign overflow_err = overflow_q;
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: the driver queues expected port writes in
// arrival order (lower requester first), a negedge monitor pops and compares them.
module tb_rf_wr_arbiter;
    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [9:0]  req_rd;
    logic [63:0] req_data;
    logic        stall;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic        overflow_err;

    rf_wr_arbiter #(.NREQ(2), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .stall        (stall),
        .wr_en        (wr_en),
        .wr_rd        (wr_rd),
        .wr_data      (wr_data),
        .overflow_err (overflow_err)
    );

    int checks = 0;
    int errors = 0;
    int write_count = 0;
    logic stall_seen = 1'b0;
    logic [36:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every port write must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (stall) stall_seen = 1'b1;
        if (!rst && wr_en) begin
            write_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual rd=%0d data=%h expected no write", wr_rd, wr_data);
            end else begin
                chk("port_write", {27'd0, wr_rd, wr_data}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    // Called just after a negedge; the push happens at the following posedge.
    task automatic drive(input logic [1:0] v, input logic [4:0] r0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [31:0] d1);
        req_valid = v;
        req_rd    = {r1, r0};
        req_data  = {d1, d0};
        if (!stall) begin
            if (v[0] && r0 != 5'd0) exp_q.push_back({r0, d0});
            if (v[1] && r1 != 5'd0) exp_q.push_back({r1, d1});
        end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    task automatic idle(input int n);
        req_valid = 2'b00;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk(name, exp_q.size(), 0);
        idle(2);
    endtask

    initial begin
        int n;
        int t;
        int wc;
        logic acc;
        rst = 1'b1;
        req_valid = 2'b00;
        req_rd = '0;
        req_data = '0;
        #12;
        chk("reset_wr_en", wr_en, 0);
        chk("reset_wr_rd", wr_rd, 0);
        chk("reset_wr_data", wr_data, 0);
        chk("reset_stall", stall, 0);
        chk("reset_overflow", overflow_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single write: stored at next edge, on the port one cycle later, for one cycle.
        drive(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0);
        chk("single_not_early", wr_en, 0);
        @(negedge clk);
        chk("single_wr_en", wr_en, 1);
        chk("single_wr_rd", wr_rd, 5);
        chk("single_wr_data", wr_data, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("single_one_cycle", wr_en, 0);
        drain("single_drain");

        // x0 discard: nothing may reach the port, and port data holds its last value.
        drive(2'b01, 5'd0, 32'h0000_1234, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("x0_no_write", wr_en, 0);
            @(negedge clk);
        end
        chk("x0_data_hold", wr_data, 32'hDEAD_BEEF);

        // Same-cycle conflict on rd 7: 0xA then 0xB.
        drive(2'b11, 5'd7, 32'h0000_000A, 5'd7, 32'h0000_000B);
        drain("conflict_drain");
        chk("conflict_final_data", wr_data, 32'h0000_000B);

        // Age priority: rd 3, then 4, then 6.
        drive(2'b10, 5'd0, 32'h0, 5'd3, 32'h0000_0033);
        drive(2'b11, 5'd4, 32'h0000_0044, 5'd6, 32'h0000_0066);
        drain("age_drain");
        chk("quiet_no_stall", stall_seen, 0);
        chk("quiet_no_overflow", overflow_err, 0);

        // Backpressure: both requesters valid every cycle, advancing only when accepted.
        stall_seen = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            acc = !stall;
            drive(2'b11, 5'(1 + ((2*n) % 31)), 32'hC000_0000 | 32'(2*n),
                         5'(1 + ((2*n+1) % 31)), 32'hC000_0000 | 32'(2*n+1));
            if (acc) n++;
        end
        drain("backpressure_drain");
        chk("backpressure_stall_seen", stall_seen, 1);
        chk("backpressure_no_overflow", overflow_err, 0);
        chk("backpressure_stall_released", stall, 0);

        // Async reset while writes are buffered and the port is active.
        drive(2'b11, 5'd10, 32'h0000_0100, 5'd11, 32'h0000_0101);
        drive(2'b11, 5'd12, 32'h0000_0102, 5'd13, 32'h0000_0103);
        t = 0;
        while (!wr_en && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("areset_port_active", wr_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("areset_wr_en", wr_en, 0);
        chk("areset_wr_rd", wr_rd, 0);
        chk("areset_wr_data", wr_data, 0);
        chk("areset_stall", stall, 0);
        chk("areset_overflow", overflow_err, 0);
        exp_q.delete();
        wc = write_count;
        idle(2);
        rst = 1'b0;
        idle(8);
        chk("areset_no_late_write", write_count, wc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
